// File: rtl/usb_rx_ring_buffer.sv
// usb_rx_ring_buffer
//   Single-clock receive FIFO between the USB RX stream and an Avalon-MM
//   slave. Words are stored as {eop, data} in a simple dual-port RAM with a
//   registered read port. A one-entry bypass lets a word pushed into an
//   empty buffer be popped on the very next cycle.
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   in_data/valid/eop       RX stream word, valid strobe, end-of-packet flag
//   in_ready                registered ~full
//   address/chipselect/     4-word register slave:
//   read/write/writedata      0 DATA (pop), 1 STATUS, 2 CONTROL, 3 COUNTS
//   readdata                read data, latency 1, held between reads
//   irq                     registered level interrupt
module usb_rx_ring_buffer #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int ALMOST_FULL = DEPTH - 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_eop,
  output logic              in_ready,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic              eop;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t mem [DEPTH];
  entry_t ram_q, byp_q, head;
  logic   byp_sel;

  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic [AW:0]   level, level_nx, pkt_count, pkt_nx;
  logic [15:0]   drop_count, drop_nx, drop_base;
  logic          overflow, underflow, last_eop, irq_en, full_q;
  logic          overflow_nx, underflow_nx, last_eop_nx, irq_en_nx;

  logic cs_rd, cs_wr, ctrl_wr, flush, clr, empty, almost_full;
  logic push, drop, pop, under;
  logic [31:0] rd_mux;

  // writedata bits above the CONTROL field are don't-care.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:3];

  assign cs_rd       = chipselect & read;
  assign cs_wr       = chipselect & write;
  assign ctrl_wr     = cs_wr & (address == 2'd2);
  assign flush       = ctrl_wr & writedata[0];
  assign clr         = ctrl_wr & writedata[1];
  assign empty       = (level == '0);
  assign almost_full = (level >= (AW+1)'(ALMOST_FULL));
  assign in_ready    = ~full_q;

  // Flush wins over anything on the stream or the DATA port that cycle.
  assign push  = in_valid & in_ready & ~flush;
  assign drop  = in_valid & ~in_ready & ~flush;
  assign pop   = cs_rd & (address == 2'd0) & ~empty & ~flush;
  assign under = cs_rd & (address == 2'd0) & empty & ~flush;

  // The head is the RAM output unless the previous edge wrote the very
  // address the RAM was reading (the buffer had just become non-empty).
  assign head = byp_sel ? byp_q : ram_q;

  always_comb begin
    wr_ptr_nx    = wr_ptr + AW'(push);
    rd_ptr_nx    = rd_ptr + AW'(pop);
    level_nx     = level;
    pkt_nx       = pkt_count;
    last_eop_nx  = last_eop;
    irq_en_nx    = irq_en;
    case ({push, pop})
      2'b10:   level_nx = level + 1'b1;
      2'b01:   level_nx = level - 1'b1;
      default: level_nx = level;
    endcase
    case ({push & in_eop, pop & head.eop})
      2'b10:   pkt_nx = pkt_count + 1'b1;
      2'b01:   pkt_nx = pkt_count - 1'b1;
      default: pkt_nx = pkt_count;
    endcase
    if (pop) last_eop_nx = head.eop;
    if (flush) begin
      wr_ptr_nx   = '0;
      rd_ptr_nx   = '0;
      level_nx    = '0;
      pkt_nx      = '0;
      last_eop_nx = 1'b0;
    end
    if (ctrl_wr) irq_en_nx = writedata[2];
    // A clear and a fresh event in the same cycle leaves the event recorded.
    overflow_nx  = clr ? drop  : (overflow  | drop);
    underflow_nx = clr ? under : (underflow | under);
    drop_base    = clr ? 16'd0 : drop_count;
    drop_nx      = (drop && drop_base != 16'hFFFF) ? drop_base + 16'd1 : drop_base;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: if (pop) rd_mux = 32'(head.data);
      2'd1: begin
        rd_mux[AW:0] = level;
        rd_mux[16]   = empty;
        rd_mux[17]   = full_q;
        rd_mux[18]   = almost_full;
        rd_mux[19]   = overflow;
        rd_mux[20]   = underflow;
        rd_mux[21]   = last_eop;
      end
      2'd2:    rd_mux[2] = irq_en;
      default: rd_mux = {drop_count, 16'(pkt_count)};
    endcase
  end

  // Storage: write port plus registered read addressed by the next read
  // pointer, so the head word is ready in the cycle a pop is issued.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{eop: in_eop, data: in_data};
    ram_q <= mem[rd_ptr_nx];
    byp_q <= '{eop: in_eop, data: in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      last_eop   <= 1'b0;
      irq_en     <= 1'b0;
      full_q     <= 1'b0;
      byp_sel    <= 1'b0;
      irq        <= 1'b0;
      readdata   <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nx;
      rd_ptr     <= rd_ptr_nx;
      level      <= level_nx;
      pkt_count  <= pkt_nx;
      drop_count <= drop_nx;
      overflow   <= overflow_nx;
      underflow  <= underflow_nx;
      last_eop   <= last_eop_nx;
      irq_en     <= irq_en_nx;
      full_q     <= (level_nx == (AW+1)'(DEPTH));
      byp_sel    <= push && (wr_ptr == rd_ptr_nx);
      irq        <= irq_en_nx & ((pkt_nx != '0) | overflow_nx);
      if (cs_rd) readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_usb_rx_ring_buffer.sv
// Directed bench for usb_rx_ring_buffer with DEPTH=16.
module tb_usb_rx_ring_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_eop = 1'b0;
  logic        in_ready;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] v;

  usb_rx_ring_buffer #(.DATA_W(32), .DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_eop(in_eop), .in_ready(in_ready),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    tick;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    tick;
    chipselect = 1'b0; write = 1'b0; writedata = '0;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    in_data = d; in_eop = e; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; in_eop = 1'b0;
  endtask

  initial begin
    // reset
    tick; tick;
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    rd_reg(2'd1, v); chk("rst_status", v, 32'h0001_0000);
    rd_reg(2'd3, v); chk("rst_counts", v, 32'h0000_0000);

    // one packet of 5 words
    for (int i = 0; i < 5; i++) push(32'h11 + 32'(i), i == 4);
    chk("pkt_irq_off", 32'(irq), 32'd0);
    rd_reg(2'd1, v); chk("pkt_status", v, 32'h0000_0005);
    rd_reg(2'd3, v); chk("pkt_counts", v, 32'h0000_0001);
    wr_reg(2'd2, 32'h4);
    chk("pkt_irq_on", 32'(irq), 32'd1);
    rd_reg(2'd2, v); chk("ctrl_read", v, 32'h0000_0004);

    // back-to-back pops
    address = 2'd0; chipselect = 1'b1; read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("pop_data", readdata, 32'h11 + 32'(i));
    end
    chipselect = 1'b0; read = 1'b0;
    rd_reg(2'd1, v); chk("pop_status", v, 32'h0021_0000);
    rd_reg(2'd3, v); chk("pop_counts", v, 32'h0000_0000);
    chk("pop_irq", 32'(irq), 32'd0);

    // fill to full, then 3 dropped words
    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i), 1'b0);
    in_data = 32'hDEAD; in_valid = 1'b1;
    tick; tick; tick;
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    rd_reg(2'd1, v); chk("full_status", v, 32'h002E_0010);
    rd_reg(2'd3, v); chk("full_counts", v, 32'h0003_0000);
    chk("full_irq", 32'(irq), 32'd1);
    wr_reg(2'd2, 32'h2);
    rd_reg(2'd1, v); chk("clr_status", v, 32'h0026_0010);
    rd_reg(2'd3, v); chk("clr_counts", v, 32'h0000_0000);
    chk("clr_irq", 32'(irq), 32'd0);
    address = 2'd0; chipselect = 1'b1; read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick;
      chk("drain_data", readdata, 32'h100 + 32'(i));
      if (i == 0) chk("drain_in_ready", 32'(in_ready), 32'd1);
    end
    chipselect = 1'b0; read = 1'b0;

    // wrap-around
    for (int i = 0; i < 10; i++) push(32'h30 + 32'(i), 1'b0);
    address = 2'd0; chipselect = 1'b1; read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("wrap_pre", readdata, 32'h30 + 32'(i));
    end
    chipselect = 1'b0; read = 1'b0;
    for (int i = 0; i < 12; i++) push(32'hA0 + 32'(i), 1'b0);
    address = 2'd0; chipselect = 1'b1; read = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("wrap_data", readdata, 32'hA0 + 32'(i));
    end
    chipselect = 1'b0; read = 1'b0;

    // concurrent push and pop at level 3
    for (int i = 0; i < 3; i++) push(32'h50 + 32'(i), 1'b0);
    address = 2'd0; chipselect = 1'b1; read = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h53 + 32'(i);
      tick;
      chk("pp_data", readdata, 32'h50 + 32'(i));
    end
    chipselect = 1'b0; read = 1'b0; in_valid = 1'b0;
    rd_reg(2'd1, v); chk("pp_status", v, 32'h0000_0003);
    for (int i = 0; i < 3; i++) begin
      rd_reg(2'd0, v); chk("pp_tail", v, 32'h64 + 32'(i));
    end

    // push into empty, pop next cycle
    push(32'h77, 1'b0);
    rd_reg(2'd0, v); chk("bypass_data", v, 32'h77);

    // underflow
    rd_reg(2'd0, v); chk("under_data", v, 32'h0);
    rd_reg(2'd1, v); chk("under_status", v, 32'h0011_0000);

    // flush racing a push at level 7
    for (int i = 0; i < 7; i++) push(32'hC0 + 32'(i), (i == 2) || (i == 6));
    rd_reg(2'd1, v); chk("pre_flush_status", v, 32'h0010_0007);
    rd_reg(2'd3, v); chk("pre_flush_counts", v, 32'h0000_0002);
    in_data = 32'hEE; in_eop = 1'b1; in_valid = 1'b1;
    wr_reg(2'd2, 32'h1);
    in_valid = 1'b0; in_eop = 1'b0;
    rd_reg(2'd1, v); chk("flush_status", v, 32'h0011_0000);
    rd_reg(2'd3, v); chk("flush_counts", v, 32'h0000_0000);
    push(32'h99, 1'b0);
    rd_reg(2'd0, v); chk("post_flush_data", v, 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
